wavetable_voice_sched: RTL and testbench
========================================

# wavetable_voice_sched

Per-frame sequencer that time-multiplexes NUM_VOICES phase accumulators over one shared wavetable read port, sums the looked-up samples and hands one mixed sample per I2S frame to the I2S transmitter. Sits between the sample memory and the serializer in the `mclk` domain. It replaces the serializer's internal index/divider playback with independent per-voice frequency control.

## Interface
- SAMPLE_BITS, 16, sample width (two's complement)
- CLIP_LEN, 64, wavetable depth; must be a power of two
- NUM_VOICES, 4, voices; must be a power of two, ≥1
- PHASE_BITS, 24, phase accumulator width; ≥ log2(CLIP_LEN)
- mclk  in  1  master clock; sole clock
- rst_n  in  1  asynchronous, active-low reset
- sample_req  in  1  one-`mclk` pulse per frame from the I2S side
- voice_en  in  NUM_VOICES  per-voice enable
- voice_inc  in  NUM_VOICES×PHASE_BITS  per-voice phase increment (unsigned)
- tbl_rd  out  1  table read strobe
- tbl_addr  out  log2(CLIP_LEN)  table address
- tbl_data  in  SAMPLE_BITS  table data, valid exactly 1 cycle after tbl_rd
- out_sample  out  SAMPLE_BITS  mixed sample
- out_valid  out  1  out_sample valid
- out_ready  in  1  transmitter accepts out_sample
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: a sample_req was dropped
- clr_overrun  in  1  clears overrun

## Operation
- States: IDLE, READ, ACC, PRESENT. v = voice counter.
- IDLE: on sample_req go to READ, v=0, acc=0.
- READ: tbl_rd=1, tbl_addr = phase[v][PHASE_BITS-1 -: log2(CLIP_LEN)] → ACC.
- ACC: if voice_en[v]: acc += sign-extended tbl_data, phase[v] += voice_inc[v] (mod 2^PHASE_BITS); else phase[v] ← 0, acc unchanged. If v==NUM_VOICES-1 → PRESENT, else v++ → READ.
- PRESENT: out_sample = acc >>> log2(NUM_VOICES) (arithmetic); out_valid=1; hold stable until out_ready; on valid&&ready → IDLE.
- acc width SAMPLE_BITS+log2(NUM_VOICES); no saturation possible.
- Phase update uses the increment sampled in ACC; the lookup uses the pre-increment phase.
- sample_req while state≠IDLE: request dropped, overrun←1. Same-cycle clr_overrun and dropped request: overrun stays 1.
- voice_en/voice_inc changes take effect at that voice's next ACC slot.
- Reset mid-frame: FSM→IDLE immediately, partial mix discarded, all phases 0.

## Timing
- Reset values: tbl_rd=0, tbl_addr=0, out_sample=0, out_valid=0, busy=0, overrun=0; all phase regs 0, acc 0.
- All outputs registered.
- sample_req sampled high at edge t0: tbl_rd high in cycle t0+1.
- Reads are at t0+1+2k for voice k. out_valid rises at t0+2·NUM_VOICES+1 (9 cycles for NUM_VOICES=4).
- out_valid falls the cycle after the valid&&ready edge. Next sample_req is accepted from that IDLE cycle.
- Worst case 2·NUM_VOICES+2 cycles ≪ 256-cycle frame; the transmitter must assert out_ready within one frame or overrun results.

## Structure
- Shared package `audio_pkg`: SAMPLE_BITS, CLIP_LEN, `sample_t` typedef, `sched_state_t` enum {IDLE, READ, ACC, PRESENT}.
- One sub-module `voice_phase_bank`: NUM_VOICES phase registers with indexed read, conditional add, clear and async reset. FSM, accumulator and output register live in the top.

## Test plan
- Bench table: table[i] = i·16.
- Reset then idle → all outputs 0, busy 0, no tbl_rd.
- Voice 0 only, inc = 1<<(PHASE_BITS-6), 3 frames → tbl_addr 0,1,2 for voice 0; out_sample 0, 4, 8 (i·16>>2).
- All 4 voices enabled, inc 0, phases 0 → out_sample 0 every frame; voice0 inc 63<<(PHASE_BITS-6), 2 frames → second frame addr 63, out_sample 252 (wrap verified on third frame: addr 62).
- Table entry −32768 in all 4 voices → out_sample −32768, no overflow.
- sample_req at t0 and t0+3; out_ready held 0 for 300 cycles → overrun=1, out_sample stable, one sample delivered on ready; clr_overrun → 0.
- rst_n low during ACC of voice 2 → outputs reset values within the same cycle; next frame restarts from phase 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample/table geometry and the voice
// scheduler state encoding.
package audio_pkg;

  localparam int unsigned SAMPLE_BITS = 16;
  localparam int unsigned CLIP_LEN    = 64;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    ACC,
    PRESENT
  } sched_state_t;

endpackage

// File: rtl/voice_phase_bank.sv
// Per-voice phase accumulators: combinational indexed read, one write port
// that either clears or adds an increment to the selected voice.
module voice_phase_bank #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_BITS = 24,
  parameter int unsigned IDX_BITS   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_BITS-1:0]   rd_idx,
  output logic [PHASE_BITS-1:0] rd_phase,
  input  logic [IDX_BITS-1:0]   wr_idx,
  input  logic                  add_en,
  input  logic                  clr_en,
  input  logic [PHASE_BITS-1:0] inc
);

  logic [PHASE_BITS-1:0] phase [NUM_VOICES];

  assign rd_phase = phase[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
    end else if (clr_en) begin
      phase[wr_idx] <= '0;
    end else if (add_en) begin
      phase[wr_idx] <= phase[wr_idx] + inc;
    end
  end

endmodule

// File: rtl/wavetable_voice_sched.sv
// Per-frame voice sequencer: reads one wavetable entry per voice over a shared
// port, mixes them and presents one averaged sample per I2S frame.
module wavetable_voice_sched #(
  parameter int unsigned SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
  parameter int unsigned CLIP_LEN    = audio_pkg::CLIP_LEN,
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned PHASE_BITS  = 24
) (
  input  logic                             mclk,
  input  logic                             rst_n,
  input  logic                             sample_req,
  input  logic [NUM_VOICES-1:0]            voice_en,
  input  logic [NUM_VOICES*PHASE_BITS-1:0] voice_inc,
  output logic                             tbl_rd,
  output logic [$clog2(CLIP_LEN)-1:0]      tbl_addr,
  input  logic [SAMPLE_BITS-1:0]           tbl_data,
  output logic [SAMPLE_BITS-1:0]           out_sample,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             overrun,
  input  logic                             clr_overrun
);
  import audio_pkg::*;

  localparam int unsigned ADDR_BITS = $clog2(CLIP_LEN);
  localparam int unsigned VSHIFT    = $clog2(NUM_VOICES);
  localparam int unsigned VBITS     = (NUM_VOICES > 1) ? VSHIFT : 1;
  localparam int unsigned ACC_BITS  = SAMPLE_BITS + VSHIFT;
  localparam logic [VBITS-1:0] LAST_V = VBITS'(NUM_VOICES - 1);

  sched_state_t state, state_nx;
  logic [VBITS-1:0]           v, v_nx;
  logic signed [ACC_BITS-1:0] acc, acc_nx, acc_sum;
  logic [PHASE_BITS-1:0]      rd_phase, cur_inc;
  logic                       ph_add, ph_clr;

  assign cur_inc = voice_inc[v*PHASE_BITS +: PHASE_BITS];

  voice_phase_bank #(
    .NUM_VOICES(NUM_VOICES),
    .PHASE_BITS(PHASE_BITS),
    .IDX_BITS  (VBITS)
  ) u_phase_bank (
    .clk     (mclk),
    .rst_n   (rst_n),
    .rd_idx  (v_nx),
    .rd_phase(rd_phase),
    .wr_idx  (v),
    .add_en  (ph_add),
    .clr_en  (ph_clr),
    .inc     (cur_inc)
  );

  always_comb begin
    state_nx = state;
    v_nx     = v;
    acc_nx   = acc;
    ph_add   = 1'b0;
    ph_clr   = 1'b0;
    acc_sum  = acc + ACC_BITS'($signed(tbl_data));
    unique case (state)
      IDLE: begin
        if (sample_req) begin
          state_nx = READ;
          v_nx     = '0;
          acc_nx   = '0;
        end
      end
      READ: state_nx = ACC;
      ACC: begin
        if (voice_en[v]) begin
          acc_nx = acc_sum;
          ph_add = 1'b1;
        end else begin
          ph_clr = 1'b1;
        end
        if (v == LAST_V) begin
          state_nx = PRESENT;
        end else begin
          v_nx     = v + 1'b1;
          state_nx = READ;
        end
      end
      PRESENT: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe; the mix is taken from acc_nx to include the last voice.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      v          <= '0;
      acc        <= '0;
      tbl_rd     <= 1'b0;
      tbl_addr   <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state     <= state_nx;
      v         <= v_nx;
      acc       <= acc_nx;
      tbl_rd    <= (state_nx == READ);
      if (state_nx == READ) tbl_addr <= rd_phase[PHASE_BITS-1 -: ADDR_BITS];
      if (state == ACC && state_nx == PRESENT)
        out_sample <= SAMPLE_BITS'(acc_nx >>> VSHIFT);
      out_valid <= (state_nx == PRESENT);
      busy      <= (state_nx != IDLE);
      if (sample_req && state != IDLE) overrun <= 1'b1;
      else if (clr_overrun)            overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wavetable_voice_sched.sv
// Scoreboard bench for wavetable_voice_sched: expected table addresses and
// mixed samples are queued by the stimulus and checked by a forked monitor.
module tb_wavetable_voice_sched;

  localparam int unsigned NV = 4;
  localparam int unsigned PB = 24;
  localparam int unsigned SB = 16;
  localparam int unsigned CL = 64;
  localparam int unsigned AB = 6;
  localparam logic [PB-1:0] U    = 24'h040000;
  localparam logic [PB-1:0] U63  = 24'hFC0000;

  logic             mclk;
  logic             rst_n;
  logic             sample_req;
  logic [NV-1:0]    voice_en;
  logic [NV*PB-1:0] voice_inc;
  logic             tbl_rd;
  logic [AB-1:0]    tbl_addr;
  logic [SB-1:0]    tbl_data;
  logic [SB-1:0]    out_sample;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             clr_overrun;

  logic [SB-1:0] tbl [CL];
  logic [AB-1:0] exp_addr [$];
  logic [SB-1:0] exp_smp  [$];
  int total;
  int bad;
  int delivered;

  wavetable_voice_sched #(
    .SAMPLE_BITS(SB),
    .CLIP_LEN   (CL),
    .NUM_VOICES (NV),
    .PHASE_BITS (PB)
  ) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .sample_req (sample_req),
    .voice_en   (voice_en),
    .voice_inc  (voice_inc),
    .tbl_rd     (tbl_rd),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Synchronous table: data valid the cycle after the read strobe.
  always @(posedge mclk) if (tbl_rd) tbl_data <= tbl[tbl_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic monitor();
    logic [AB-1:0] ea;
    logic [SB-1:0] es;
    forever begin
      @(negedge mclk);
      if (rst_n && tbl_rd) begin
        total++;
        if (exp_addr.size() == 0) begin
          bad++;
          $display("FAIL tbl_addr: got=%0d want=no read", tbl_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (tbl_addr !== ea) begin
            bad++;
            $display("FAIL tbl_addr: got=%0d want=%0d", tbl_addr, ea);
          end
        end
      end
      if (rst_n && out_valid && out_ready) begin
        delivered++;
        total++;
        if (exp_smp.size() == 0) begin
          bad++;
          $display("FAIL out_sample: got=%0d want=no sample", $signed(out_sample));
        end else begin
          es = exp_smp.pop_front();
          if (out_sample !== es) begin
            bad++;
            $display("FAIL out_sample: got=%0d want=%0d", $signed(out_sample), $signed(es));
          end
        end
      end
    end
  endtask

  task automatic exp_frame(input int a0, input int a1, input int a2, input int a3,
                           input int smp);
    exp_addr.push_back(AB'(a0));
    exp_addr.push_back(AB'(a1));
    exp_addr.push_back(AB'(a2));
    exp_addr.push_back(AB'(a3));
    exp_smp.push_back(SB'(smp));
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake completes.
  task automatic run_frame();
    int n;
    sample_req = 1'b1;
    @(posedge mclk); #1;
    sample_req = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge mclk); #1;
      n++;
    end
    chk("valid_latency", n, 2 * NV);
    n = 0;
    while (out_valid && n < 400) begin
      @(posedge mclk); #1;
      n++;
    end
    if (out_valid) chk("handshake_timeout", 1, 0);
  endtask

  initial begin
    int n;
    int d0;
    total = 0; bad = 0; delivered = 0;
    rst_n = 1'b0; sample_req = 1'b0; voice_en = '0; voice_inc = '0;
    out_ready = 1'b1; clr_overrun = 1'b0;
    for (int i = 0; i < int'(CL); i++) tbl[i] = SB'(i * 16);
    fork monitor(); join_none

    // Reset and idle
    repeat (3) @(posedge mclk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge mclk);
    #1;
    chk("rst_tbl_rd", int'(tbl_rd), 0);
    chk("rst_tbl_addr", int'(tbl_addr), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);

    // Voice 0 alone, one address step per frame
    voice_en = 4'b0001;
    voice_inc[0 +: PB] = U;
    exp_frame(0, 0, 0, 0, 0); run_frame();
    exp_frame(1, 0, 0, 0, 4); run_frame();
    exp_frame(2, 0, 0, 0, 8); run_frame();

    // Clear phases, then all voices at zero increment
    voice_en = 4'b0000;
    exp_frame(3, 0, 0, 0, 0); run_frame();
    voice_en = 4'b1111;
    voice_inc = '0;
    exp_frame(0, 0, 0, 0, 0); run_frame();
    exp_frame(0, 0, 0, 0, 0); run_frame();

    // Voice 0 jumps 63 entries per frame: 0 -> 63 -> 62 (wrap)
    voice_inc[0 +: PB] = U63;
    exp_frame(0, 0, 0, 0, 0); run_frame();
    exp_frame(63, 0, 0, 0, 252); run_frame();
    exp_frame(62, 0, 0, 0, 248); run_frame();

    // Most negative entry in all voices
    voice_en = 4'b0000;
    exp_frame(61, 0, 0, 0, 0); run_frame();
    voice_en = 4'b1111;
    voice_inc = '0;
    tbl[0] = 16'h8000;
    exp_frame(0, 0, 0, 0, -32768); run_frame();

    // Overrun: second request dropped, transmitter stalls
    tbl[0] = 16'd100;
    out_ready = 1'b0;
    exp_frame(0, 0, 0, 0, 100);
    d0 = delivered;
    sample_req = 1'b1;
    @(posedge mclk); #1 sample_req = 1'b0;
    @(posedge mclk);
    @(posedge mclk); #1 sample_req = 1'b1;
    @(posedge mclk); #1 sample_req = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge mclk); #1;
      n++;
    end
    chk("ovr_valid_seen", int'(out_valid), 1);
    sample_req = 1'b1; clr_overrun = 1'b1;
    @(posedge mclk); #1;
    sample_req = 1'b0; clr_overrun = 1'b0;
    chk("overrun_set_beats_clr", int'(overrun), 1);
    repeat (300) @(posedge mclk);
    #1;
    chk("stall_valid_held", int'(out_valid), 1);
    chk("stall_sample_stable", int'(out_sample), 100);
    chk("stall_no_delivery", delivered, d0);
    out_ready = 1'b1;
    @(posedge mclk); #1;
    chk("valid_falls_after_hs", int'(out_valid), 0);
    chk("one_delivered", delivered, d0 + 1);
    clr_overrun = 1'b1;
    @(posedge mclk); #1 clr_overrun = 1'b0;
    chk("overrun_cleared", int'(overrun), 0);
    tbl[0] = 16'd0;

    // Reset during ACC of voice 2, then restart from phase 0
    for (int k = 0; k < int'(NV); k++) voice_inc[k*PB +: PB] = U;
    exp_frame(0, 0, 0, 0, 0); run_frame();
    exp_addr.push_back(AB'(1));
    exp_addr.push_back(AB'(1));
    exp_addr.push_back(AB'(1));
    sample_req = 1'b1;
    @(posedge mclk); #1 sample_req = 1'b0;
    repeat (5) @(posedge mclk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tbl_rd", int'(tbl_rd), 0);
    chk("mid_rst_tbl_addr", int'(tbl_addr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_sample", int'(out_sample), 0);
    chk("mid_rst_reads_done", exp_addr.size(), 0);
    @(posedge mclk); #1 rst_n = 1'b1;
    exp_frame(0, 0, 0, 0, 0); run_frame();
    exp_frame(1, 1, 1, 1, 16); run_frame();

    repeat (5) @(posedge mclk);
    #1;
    chk("addr_queue_drained", exp_addr.size(), 0);
    chk("sample_queue_drained", exp_smp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
